// File: rtl/text_writer.sv
// Byte-stream interpreter: turns received UART bytes into {attr, glyph} text RAM writes,
// tracking the cursor and colour attribute and executing backspace/newline/colour/clear.
module text_writer #(
  parameter int          COLUMNS      = 80,
  parameter int          ROWS         = 30,
  parameter logic [7:0]  DEFAULT_ATTR = 8'h70
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  RxData_i,
  input  logic        RxDone_i,
  output logic [11:0] Address_o,
  output logic [15:0] Data_o,
  output logic        WriteEnable_o,
  output logic [11:0] CursorAddress_o,
  output logic        Busy_o,
  output logic        Overrun_o
);

  localparam int CW    = $clog2(COLUMNS);
  localparam int RW    = $clog2(ROWS);
  localparam int CELLS = COLUMNS * ROWS;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    attr_q, attr_d;
  logic [11:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          we_q, we_d;
  logic [11:0]   cursor_q, cursor_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;
  logic [11:0]   sweep_q, sweep_d;

  function automatic logic [11:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return 12'(r) * 12'(COLUMNS) + 12'(c);
  endfunction

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    attr_d  = attr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    ovr_d   = 1'b0;
    sweep_d = sweep_q;

    case (state_q)
      IDLE: begin
        if (RxDone_i) begin
          if (RxData_i[7]) begin
            attr_d = {1'b0, RxData_i[6:0]};
          end else if (RxData_i == 8'h08) begin
            if (col_q != '0 || row_q != '0) begin
              if (col_q == '0) begin
                col_d = CW'(COLUMNS - 1);
                row_d = row_q - RW'(1);
              end else begin
                col_d = col_q - CW'(1);
              end
              we_d   = 1'b1;
              addr_d = cell_addr(row_d, col_d);
              data_d = {attr_q, 8'h20};
            end
          end else if (RxData_i == 8'h13) begin
            col_d = '0;
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
          end else if (RxData_i == 8'h0C) begin
            state_d = CLEAR;
            sweep_d = '0;
          end else begin
            we_d   = 1'b1;
            addr_d = cell_addr(row_q, col_q);
            data_d = {attr_q, RxData_i};
            if (col_q == CW'(COLUMNS - 1)) begin
              col_d = '0;
              row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      CLEAR: begin
        // One blank cell per cycle; incoming bytes cannot be queued, so flag them.
        busy_d = 1'b1;
        we_d   = 1'b1;
        addr_d = sweep_q;
        data_d = {attr_q, 8'h20};
        ovr_d  = RxDone_i;
        if (sweep_q == 12'(CELLS - 1)) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          sweep_d = sweep_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    cursor_d = cell_addr(row_d, col_d);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      attr_q   <= DEFAULT_ATTR;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      cursor_q <= '0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      sweep_q  <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      attr_q   <= attr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      cursor_q <= cursor_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      sweep_q  <= sweep_d;
    end
  end

  assign Address_o       = addr_q;
  assign Data_o          = data_q;
  assign WriteEnable_o   = we_q;
  assign CursorAddress_o = cursor_q;
  assign Busy_o          = busy_q;
  assign Overrun_o       = ovr_q;

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: stimulus pushes expected {address, data} writes,
// a negedge monitor pops and compares every WriteEnable_o cycle.
module tb_text_writer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  RxData = 8'h00;
  logic        RxDone = 1'b0;
  logic [11:0] Address_o;
  logic [15:0] Data_o;
  logic        WriteEnable_o;
  logic [11:0] CursorAddress_o;
  logic        Busy_o;
  logic        Overrun_o;

  int passed = 0;
  int total  = 0;
  logic [27:0] sb[$];

  text_writer dut (
    .Clock(Clock), .Reset(Reset), .RxData_i(RxData), .RxDone_i(RxDone),
    .Address_o(Address_o), .Data_o(Data_o), .WriteEnable_o(WriteEnable_o),
    .CursorAddress_o(CursorAddress_o), .Busy_o(Busy_o), .Overrun_o(Overrun_o)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_wr(input logic [11:0] a, input logic [15:0] d);
    sb.push_back({a, d});
  endtask

  // Caller sits at #1 after a rising edge; returns #1 after the sampling edge.
  task automatic send(input logic [7:0] b);
    RxData = b;
    RxDone = 1'b1;
    @(posedge Clock); #1;
    RxDone = 1'b0;
    $display("sent %02h cursor=%0d", b, CursorAddress_o);
  endtask

  initial begin : monitor
    logic [27:0] e;
    forever begin
      @(negedge Clock);
      if (Reset && WriteEnable_o) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {4'h0, Address_o, Data_o}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("write_addr", 32'(Address_o), 32'(e[27:16]));
          check("write_data", 32'(Data_o), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin : stimulus
    int busy_cnt, ovr_cnt, guard;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_addr", 32'(Address_o), 0);
    check("rst_data", 32'(Data_o), 0);
    check("rst_we", 32'(WriteEnable_o), 0);
    check("rst_cursor", 32'(CursorAddress_o), 0);
    check("rst_busy", 32'(Busy_o), 0);
    check("rst_ovr", 32'(Overrun_o), 0);
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    check("idle_we", 32'(WriteEnable_o), 0);

    // Two glyphs
    expect_wr(12'd0, 16'h7041);
    expect_wr(12'd1, 16'h7042);
    send(8'h41);
    send(8'h42);
    check("ab_cursor", 32'(CursorAddress_o), 2);

    // Clear sweep with a byte dropped mid-way
    for (int i = 0; i < 2400; i++) expect_wr(12'(i), 16'h7020);
    send(8'h0C);
    check("clr_busy_n", 32'(Busy_o), 0);
    busy_cnt = 0;
    ovr_cnt  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 100) begin RxData = 8'h5A; RxDone = 1'b1; end
      @(posedge Clock); #1;
      RxDone = 1'b0;
      if (Busy_o) busy_cnt++;
      if (Overrun_o) ovr_cnt++;
      if (i > 10 && !Busy_o) break;
    end
    check("clr_busy_cycles", 32'(busy_cnt), 2400);
    check("clr_overrun", 32'(ovr_cnt), 1);
    check("clr_cursor", 32'(CursorAddress_o), 0);
    check("clr_we_after", 32'(WriteEnable_o), 0);

    // Colour alternation fills the screen, then wraps to 0
    for (int i = 0; i < 1200; i++) begin
      expect_wr(12'(2 * i), 16'h5001);
      expect_wr(12'(2 * i + 1), 16'h3001);
      send(8'hD0); send(8'h01); send(8'hB0); send(8'h01);
    end
    check("fill_cursor", 32'(CursorAddress_o), 0);
    expect_wr(12'd0, 16'h3041);
    send(8'h41);
    check("wrap_cursor", 32'(CursorAddress_o), 1);

    // Backspace
    expect_wr(12'd0, 16'h3020);
    send(8'h08);
    check("bs_to0_cursor", 32'(CursorAddress_o), 0);
    send(8'h08);
    check("bs_at0_we", 32'(WriteEnable_o), 0);
    check("bs_at0_cursor", 32'(CursorAddress_o), 0);
    send(8'hF0);
    expect_wr(12'd0, 16'h7041);
    expect_wr(12'd1, 16'h7042);
    expect_wr(12'd2, 16'h7043);
    expect_wr(12'd2, 16'h7020);
    send(8'h41); send(8'h42); send(8'h43); send(8'h08);
    check("bs_abc_cursor", 32'(CursorAddress_o), 2);
    send(8'h13);
    check("nl_cursor80", 32'(CursorAddress_o), 80);
    check("nl_we", 32'(WriteEnable_o), 0);
    expect_wr(12'd79, 16'h7020);
    send(8'h08);
    check("bs_row_cursor", 32'(CursorAddress_o), 79);

    // Newline
    for (int i = 0; i < 6; i++) begin
      expect_wr(12'(79 + i), 16'h7061 + 16'(i));
      send(8'h61 + 8'(i));
    end
    check("pre_nl_cursor", 32'(CursorAddress_o), 85);
    send(8'h13);
    check("nl85_cursor", 32'(CursorAddress_o), 160);
    repeat (27) send(8'h13);
    check("row29_cursor", 32'(CursorAddress_o), 2320);
    send(8'h13);
    check("nl_wrap_cursor", 32'(CursorAddress_o), 0);

    // Reset during a sweep
    for (int i = 0; i < 2400; i++) expect_wr(12'(i), 16'h7020);
    send(8'h0C);
    guard = 0;
    while (sb.size() > 1400 && guard < 3000) begin
      @(negedge Clock); #1;
      guard++;
    end
    check("sweep_reached_1000", 32'(sb.size()), 1400);
    Reset = 1'b0;
    #1;
    check("mid_rst_addr", 32'(Address_o), 0);
    check("mid_rst_data", 32'(Data_o), 0);
    check("mid_rst_we", 32'(WriteEnable_o), 0);
    check("mid_rst_busy", 32'(Busy_o), 0);
    check("mid_rst_cursor", 32'(CursorAddress_o), 0);
    sb.delete();
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("post_rst_busy", 32'(Busy_o), 0);
    expect_wr(12'd0, 16'h7051);
    send(8'h51);
    check("post_rst_cursor", 32'(CursorAddress_o), 1);

    repeat (3) @(posedge Clock);
    #1;
    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/text_writer.md
# text_writer

Byte-stream interpreter between the UART receiver and the text RAM of the VGA text terminal. It consumes received bytes and turns them into text RAM writes. Each write is a 16-bit cell of {attribute, glyph code} at the current cursor address. The block keeps the cursor position and current colour attribute, and executes the control codes backspace, newline, colour change and clear screen.

## Interface
- COLUMNS, 80, characters per row
- ROWS, 30, rows per screen; COLUMNS*ROWS ≤ 4096
- DEFAULT_ATTR, 8'h70, attribute after reset (white on black)

- Clock  in  1  system clock (pixel clock domain)
- Reset  in  1  asynchronous, active-low reset
- RxData_i  in  8  received byte, valid while RxDone_i is high
- RxDone_i  in  1  one-cycle strobe, byte available
- Address_o  out  12  text RAM write address, Row*COLUMNS+Column
- Data_o  out  16  {attribute[7:0], glyph[7:0]}
- WriteEnable_o  out  1  text RAM write strobe
- CursorAddress_o  out  12  current cursor address, for the cursor overlay
- Busy_o  out  1  high while a clear-screen sweep runs
- Overrun_o  out  1  one-cycle pulse, byte dropped

## Operation
- Cursor state: Column 0..COLUMNS-1, Row 0..ROWS-1. Attr is an 8-bit register.
- FSM states are IDLE and CLEAR.
- In IDLE, RxDone_i sampled high is decoded as follows:
  - 8'h80–8'hFF: colour command. Attr <= {1'b0, RxData_i[6:0]}. Bits 6:4 are foreground RGB, bit 3 is reserved, bits 2:0 are background RGB. No write, cursor unchanged.
  - 8'h08 (backspace), cursor not at 0: step back one cell, wrapping from column 0 to column COLUMNS-1 of the previous row. Write {Attr, 8'h20} at the new position.
  - 8'h08 at address 0: no action.
  - 8'h13 (newline): Column <= 0, Row <= Row+1. Row ROWS-1 wraps to 0. No write.
  - 8'h0C (clear screen): enter CLEAR.
  - Any other 8'h00–8'h7F: glyph. Write {Attr, RxData_i} at the cursor, then advance the cursor.
- Cursor advance: Column+1. At the last column, Column <= 0 and Row+1. The last cell (2399 with defaults) wraps to 0. There is no scrolling.
- CLEAR: writes {Attr, 8'h20} to addresses 0..COLUMNS*ROWS-1, one per cycle, with Busy_o high. After the last address the cursor is set to 0 and the FSM returns to IDLE.
- RxDone_i high while in CLEAR: the byte is discarded and Overrun_o pulses for one cycle.

## Timing
- Reset values:
  - Address_o=0, Data_o=0, WriteEnable_o=0
  - CursorAddress_o=0, Busy_o=0, Overrun_o=0
  - Attr=DEFAULT_ATTR, state IDLE
- All outputs are registered. The RxDone_i sample edge is edge n.
  - From edge n: WriteEnable_o=1 for exactly one cycle, with Address_o and Data_o valid during the same cycle.
  - From edge n: CursorAddress_o shows the post-command position.
- Back-to-back RxDone_i on consecutive cycles are all accepted in IDLE; each gives one write.
- Clear-screen timing (0x0C sampled at edge n):
  - Busy_o and WriteEnable_o are high from edge n+1 through edge n+COLUMNS*ROWS.
  - The address runs 0..COLUMNS*ROWS-1 over that window.
  - Busy_o and WriteEnable_o are low after edge n+COLUMNS*ROWS+1.
  - CursorAddress_o=0 from edge n+COLUMNS*ROWS+1.
- A colour command and the following glyph on the next cycle: the glyph uses the new Attr.
- Reset asserted mid-CLEAR: immediately all outputs return to reset values and the state returns to IDLE. The sweep is abandoned and RAM contents are undefined.
- Address arithmetic is computed from Row and Column, never by incrementing Address_o. All wrap comparisons are against COLUMNS-1 and ROWS-1.

## Test plan
- Reset, release, no input: all outputs 0, CursorAddress_o=0.
- Send "A", then "B": write {8'h70, 8'h41} @0, then {8'h70, 8'h42} @1; CursorAddress_o=2.
- Send 8'hD0, then 8'h01, then 8'hB0, then 8'h01:
  - Writes are {8'h50, 8'h01} @0 and {8'h30, 8'h01} @1.
  - Repeating the pattern 1200 times fills all 2400 cells; the next glyph writes @0.
- Backspace handling:
  - 8'h08 at address 0: no write.
  - "ABC" then 8'h08: write {Attr, 8'h20} @2, cursor=2.
  - Cursor at 80, then 8'h08: write @79, cursor=79.
- Newline handling:
  - 8'h13 at cursor 85: cursor=160, no write.
  - 8'h13 on row 29: cursor=0.
- Clear and overrun:
  - 8'h0C produces 2400 consecutive writes of {Attr, 8'h20} at addresses 0..2399; Busy_o high for 2400 cycles.
  - A byte sent mid-sweep gives an Overrun_o pulse and no extra write.
  - Reset asserted at write 1000 returns all outputs to 0 in the same cycle.
